// File: rtl/branch_pc_sequencer.sv
// PC sequencer fed by the branch evaluator's taken bit: advances or redirects the fetch PC,
// raises a timed flush on redirects and keeps saturating branch/taken statistics.
module branch_pc_sequencer #(
    parameter int unsigned    PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned    FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_pc,
    input  logic [15:0]     br_offset,
    output logic [PC_W-1:0] pc_out,
    output logic            fetch_valid,
    output logic            flush,
    output logic            redirect,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     taken_cnt
);

    localparam int unsigned FCNT_W  = 3;
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [FCNT_W-1:0] fcnt;
    logic [PC_W-1:0]   off_ext;
    logic [PC_W-1:0]   br_base;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   pc_seq;

    // Target is word aligned: branch PC low bits are dropped, offset is in words.
    assign off_ext = PC_W'($signed(br_offset));
    assign br_base = br_pc & ~PC_W'(3);
    assign target  = br_base + PC_W'(4) + (off_ext << 2);
    assign pc_seq  = pc_out + PC_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            pc_out      <= RESET_PC;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            branch_cnt  <= '0;
            taken_cnt   <= '0;
            fcnt        <= '0;
        end else begin
            redirect <= 1'b0;
            case (state)
                INIT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    flush <= 1'b0;
                    if (!stall) begin
                        if (br_valid && br_taken) begin
                            pc_out   <= target;
                            redirect <= 1'b1;
                            flush    <= 1'b1;
                            fcnt     <= FCNT_W'(FLUSH_CYC - 1);
                            state    <= (FLUSH_CYC == 1) ? RUN : FLUSH;
                            if (taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + CNT_W'(1);
                        end else begin
                            pc_out <= pc_seq;
                        end
                        if (br_valid && branch_cnt != CNT_MAX) begin
                            branch_cnt <= branch_cnt + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Wrong-path branches are ignored; the countdown runs through stalls.
                    if (!stall) pc_out <= pc_seq;
                    if (fcnt == '0) begin
                        flush <= 1'b0;
                        state <= RUN;
                    end else begin
                        fcnt <= fcnt - FCNT_W'(1);
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer: directed vector table, async-reset and
// saturation sequences, then random traffic against a cycle-level behavioural model.
module tb_branch_pc_sequencer;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned FLUSH_CYC = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [15:0] br_offset;
    logic [31:0] pc_out;
    logic        fetch_valid;
    logic        flush;
    logic        redirect;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;

    int total = 0;
    int bad   = 0;

    branch_pc_sequencer #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_pc      (br_pc),
        .br_offset  (br_offset),
        .pc_out     (pc_out),
        .fetch_valid(fetch_valid),
        .flush      (flush),
        .redirect   (redirect),
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        valid;
        logic        taken;
        logic [31:0] bpc;
        logic [15:0] off;
        logic [31:0] epc;
        logic        efl;
        logic        erd;
        logic [15:0] eb;
        logic [15:0] et;
    } vec_t;

    vec_t vecs [19];

    // Behavioural model: flush tracked as "cycles of flush still owed".
    bit          m_started;
    logic [31:0] m_pc;
    int          m_left;
    bit          m_redirect;
    int          m_b;
    int          m_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started  = 0;
        m_pc       = RESET_PC;
        m_left     = 0;
        m_redirect = 0;
        m_b        = 0;
        m_t        = 0;
    endtask

    task automatic model_edge(input bit s, input bit v, input bit t,
                              input logic [31:0] bpc, input logic [15:0] off);
        bit blocked;
        bit acc;
        int soff;
        m_redirect = 0;
        if (!m_started) begin
            m_started = 1;
        end else begin
            blocked = (m_left > 0) && (FLUSH_CYC > 1);
            acc     = !s && v && !blocked;
            if (m_left > 0) m_left--;
            if (acc && t) begin
                soff       = int'($signed(off));
                m_pc       = (bpc - (bpc % 4)) + 32'd4 + 32'(soff * 4);
                m_redirect = 1;
                m_left     = FLUSH_CYC;
                m_t        = (m_t < 65535) ? m_t + 1 : 65535;
            end else if (!s) begin
                m_pc = m_pc + 32'd4;
            end
            if (acc) m_b = (m_b < 65535) ? m_b + 1 : 65535;
        end
    endtask

    task automatic drive(input bit s, input bit v, input bit t,
                         input logic [31:0] bpc, input logic [15:0] off);
        stall     = s;
        br_valid  = v;
        br_taken  = t;
        br_pc     = bpc;
        br_offset = off;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_pc = '0; br_offset = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //               stall valid taken bpc           off       epc           fl   rd   b      t
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'h0,        1'b0,1'b0,16'd0,16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'h4,        1'b0,1'b0,16'd0,16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'h8,        1'b0,1'b0,16'd0,16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'hC,        1'b0,1'b0,16'd0,16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h40,       16'h0003, 32'h50,       1'b1,1'b1,16'd1,16'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'h54,       1'b1,1'b0,16'd1,16'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'h58,       1'b0,1'b0,16'd1,16'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0,        16'hFFFE, 32'hFFFF_FFFC,1'b1,1'b1,16'd2,16'd2};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'h0,        1'b1,1'b0,16'd2,16'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'h4,        1'b0,1'b0,16'd2,16'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h123,      16'h0010, 32'h8,        1'b0,1'b0,16'd3,16'd2};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h123,      16'h0010, 32'h8,        1'b0,1'b0,16'd3,16'd2};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h123,      16'h0010, 32'h8,        1'b0,1'b0,16'd3,16'd2};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h123,      16'h0010, 32'h8,        1'b0,1'b0,16'd3,16'd2};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'hC,        1'b0,1'b0,16'd3,16'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h103,      16'h0010, 32'h144,      1'b1,1'b1,16'd4,16'd3};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h500,      16'h0004, 32'h144,      1'b1,1'b0,16'd4,16'd3};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 32'h500,      16'h0004, 32'h148,      1'b0,1'b0,16'd4,16'd3};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'h14C,      1'b0,1'b0,16'd4,16'd3};

        do_reset();
        check("reset_pc",          pc_out,      RESET_PC);
        check("reset_fetch_valid", 32'(fetch_valid), 32'd0);
        check("reset_flush",       32'(flush),       32'd0);
        check("reset_counts",      {branch_cnt, taken_cnt}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].stall, vecs[i].valid, vecs[i].taken, vecs[i].bpc, vecs[i].off);
            check($sformatf("vec%0d_pc", i),       pc_out,            vecs[i].epc);
            check($sformatf("vec%0d_fv", i),       32'(fetch_valid),  32'd1);
            check($sformatf("vec%0d_flush", i),    32'(flush),        32'(vecs[i].efl));
            check($sformatf("vec%0d_redirect", i), 32'(redirect),     32'(vecs[i].erd));
            check($sformatf("vec%0d_bcnt", i),     32'(branch_cnt),   32'(vecs[i].eb));
            check($sformatf("vec%0d_tcnt", i),     32'(taken_cnt),    32'(vecs[i].et));
        end

        // Async reset in the middle of a flush window, between clock edges.
        drive(1'b0, 1'b1, 1'b1, 32'h200, 16'h0);
        check("pre_rst_flush", 32'(flush), 32'd1);
        br_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_flush",    32'(flush),       32'd0);
        check("async_rst_pc",       pc_out,           RESET_PC);
        check("async_rst_counts",   {branch_cnt, taken_cnt}, 32'd0);
        check("async_rst_fv",       32'(fetch_valid), 32'd0);
        check("async_rst_redirect", 32'(redirect),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation: first edge is INIT, then 65535 accepted not-taken branches and a few more.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 16'h0);
        check("sat_init_bcnt", 32'(branch_cnt), 32'd0);
        stall = 1'b0; br_valid = 1'b1; br_taken = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        check("sat_reach", 32'(branch_cnt), 32'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold_bcnt", 32'(branch_cnt), 32'hFFFF);
        check("sat_hold_tcnt", 32'(taken_cnt),  32'd0);

        // Random traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            bit s, v, t;
            logic [31:0] bpc;
            logic [15:0] off;
            s   = ($urandom_range(3) == 0);
            v   = $urandom_range(1) == 1;
            t   = $urandom_range(1) == 1;
            bpc = $urandom;
            off = 16'($urandom);
            drive(s, v, t, bpc, off);
            model_edge(s, v, t, bpc, off);
            check("rnd_pc",       pc_out,           m_pc);
            check("rnd_fv",       32'(fetch_valid), 32'(m_started));
            check("rnd_flush",    32'(flush),       32'(m_left > 0));
            check("rnd_redirect", 32'(redirect),    32'(m_redirect));
            check("rnd_bcnt",     32'(branch_cnt),  32'(m_b));
            check("rnd_tcnt",     32'(taken_cnt),   32'(m_t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
